// File: rtl/vram_arbiter.sv
// ============================================================================
// Module   : vram_arbiter
// Brief    : Two-port (video scanout / CPU) arbiter for a single-port SRAM.
//            Video has priority, and the CPU is served after a bounded streak.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_arbiter #(
    parameter int ACCESS_CYCLES  = 2,
    parameter int CPU_STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vid_req,
    input  logic [15:0] vid_addr,
    output logic        vid_ack,
    output logic [15:0] vid_rdata,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_oe,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] C_LAST   = 4'(ACCESS_CYCLES - 1);
    localparam logic [7:0] C_STARVE = 8'(CPU_STARVE_MAX);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [7:0]  r_streak;
    logic        r_owner_cpu;
    logic        r_we;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_vid_rdata;
    logic [15:0] r_cpu_rdata;

    logic        w_grant;
    logic        w_cpu_wins;
    logic        w_last;

    // The CPU only overrides a pending video request once the streak is full.
    assign w_cpu_wins = cpu_req && (!vid_req || (r_streak == C_STARVE));
    assign w_grant    = (r_state == S_IDLE) && (vid_req || cpu_req);
    assign w_last     = (r_state == S_ACCESS) && (r_cnt == C_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (vid_req || cpu_req) w_next = S_ACCESS;
            S_ACCESS: if (r_cnt == C_LAST)    w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= 4'd0;
            r_streak    <= 8'd0;
            r_owner_cpu <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 16'd0;
            r_wdata     <= 16'd0;
            r_vid_rdata <= 16'd0;
            r_cpu_rdata <= 16'd0;
        end else begin
            if (w_grant) begin
                r_cnt       <= 4'd0;
                r_owner_cpu <= w_cpu_wins;
                r_we        <= w_cpu_wins && cpu_we;
                r_addr      <= w_cpu_wins ? cpu_addr : vid_addr;
                if (w_cpu_wins) begin
                    r_wdata  <= cpu_wdata;
                    r_streak <= 8'd0;
                end else if (cpu_req) begin
                    if (r_streak != C_STARVE) r_streak <= r_streak + 8'd1;
                end else begin
                    r_streak <= 8'd0;
                end
            end
            if (r_state == S_ACCESS) begin
                r_cnt <= r_cnt + 4'd1;
            end
            // Writes leave the CPU read register untouched.
            if (w_last) begin
                if (!r_owner_cpu) begin
                    r_vid_rdata <= mem_rdata;
                end else if (!r_we) begin
                    r_cpu_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_we    = (r_state == S_ACCESS) && r_we;
    assign mem_oe    = (r_state == S_ACCESS) && !r_we;
    assign vid_ack   = (r_state == S_DONE) && !r_owner_cpu;
    assign cpu_ack   = (r_state == S_DONE) && r_owner_cpu;
    assign vid_rdata = r_vid_rdata;
    assign cpu_rdata = r_cpu_rdata;

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// Module   : tb_vram_arbiter
// Brief    : Directed, table-driven self-checking bench for vram_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic        vid_ack;
    logic [15:0] vid_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_oe;
    logic [15:0] mem_rdata;

    always #5 clk = ~clk;

    vram_arbiter #(
        .ACCESS_CYCLES (2),
        .CPU_STARVE_MAX(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .vid_req  (vid_req),
        .vid_addr (vid_addr),
        .vid_ack  (vid_ack),
        .vid_rdata(vid_rdata),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack  (cpu_ack),
        .cpu_rdata(cpu_rdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_oe   (mem_oe),
        .mem_rdata(mem_rdata)
    );

    // SRAM model: 256 words aliased on addr[7:0], preset to 16'h5A00 | index.
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h5A00 | 16'(i);
        end else if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[7:0]];

    typedef struct {
        bit          is_cpu;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("ack_overlap", 32'(vid_ack & cpu_ack), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int   lat;
        int   we_cnt;
        int   oe_cnt;
        bit   addr_ok;
        bit   got_cpu;
        logic [15:0] rd;
        lat = -1; we_cnt = 0; oe_cnt = 0; addr_ok = 1'b1; got_cpu = 1'b0; rd = 16'd0;
        @(negedge clk);
        if (v.is_cpu) begin
            cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end else begin
            vid_req = 1'b1; vid_addr = v.addr;
        end
        for (int k = 1; k <= 12 && lat < 0; k++) begin
            tick();
            if (mem_we) we_cnt++;
            if (mem_oe) oe_cnt++;
            if ((mem_we || mem_oe) && mem_addr !== v.addr) addr_ok = 1'b0;
            if (mem_we && mem_wdata !== v.wdata) addr_ok = 1'b0;
            if (vid_ack || cpu_ack) begin
                lat = k; got_cpu = cpu_ack;
                rd = v.is_cpu ? cpu_rdata : vid_rdata;
            end
        end
        vid_req = 1'b0;
        cpu_req = 1'b0;
        check("vec_latency", 32'(lat), 32'd3);
        check("vec_owner", 32'(got_cpu), 32'(v.is_cpu));
        check("vec_rdata", 32'(rd), 32'(v.exp_rdata));
        check("vec_we_cycles", 32'(we_cnt), v.we ? 32'd2 : 32'd0);
        check("vec_oe_cycles", 32'(oe_cnt), v.we ? 32'd0 : 32'd2);
        check("vec_mem_bus", 32'(addr_ok), 32'd1);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vlat;
        int clat;
        int acks;
        int last;
        int ack_cnt;
        int ack_lat;
        int cpu_seen;

        vecs[0] = '{1'b1, 1'b1, 16'h1234, 16'hBEEF, 16'h0000};
        vecs[1] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 16'hBEEF};
        vecs[2] = '{1'b1, 1'b1, 16'h0042, 16'hA5A5, 16'hBEEF};
        vecs[3] = '{1'b0, 1'b0, 16'h0042, 16'h0000, 16'hA5A5};
        vecs[4] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h5A10};
        vecs[5] = '{1'b1, 1'b0, 16'h0077, 16'h0000, 16'h5A77};
        vecs[6] = '{1'b1, 1'b1, 16'h00FF, 16'h1357, 16'h5A77};
        vecs[7] = '{1'b0, 1'b0, 16'h00FF, 16'h0000, 16'h1357};
        vecs[8] = '{1'b0, 1'b0, 16'h0034, 16'h0000, 16'hBEEF};

        reset = 1'b1; vid_req = 1'b0; vid_addr = 16'd0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'd0; cpu_wdata = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_acks", 32'({vid_ack, cpu_ack}), 32'd0);
        check("rst_mem_ctl", 32'({mem_we, mem_oe}), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_rdata", 32'({vid_rdata, cpu_rdata}), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Simultaneous first request: video first, CPU one access period later.
        vlat = -1; clat = -1;
        @(negedge clk);
        vid_req = 1'b1; vid_addr = 16'h0010;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0077;
        for (int k = 1; k <= 20 && clat < 0; k++) begin
            tick();
            if (vid_ack && vlat < 0) begin vlat = k; vid_req = 1'b0; end
            if (cpu_ack) begin clat = k; cpu_req = 1'b0; end
        end
        vid_req = 1'b0; cpu_req = 1'b0;
        check("simul_vid_lat", 32'(vlat), 32'd3);
        check("simul_cpu_lat", 32'(clat), 32'd7);
        check("simul_cpu_rdata", 32'(cpu_rdata), 32'h5A77);
        tick();

        // Both held: 8 video grants then 1 CPU, repeating, one ack every 4 cycles.
        acks = 0; last = 0;
        @(negedge clk);
        vid_req = 1'b1; vid_addr = 16'h0010;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0042;
        for (int k = 1; k <= 100 && acks < 18; k++) begin
            tick();
            if (vid_ack || cpu_ack) begin
                check("starve_owner", 32'(cpu_ack), 32'((acks % 9) == 8));
                if (acks > 0) check("starve_spacing", 32'(k - last), 32'd4);
                last = k;
                acks++;
                if (acks == 18) begin vid_req = 1'b0; cpu_req = 1'b0; end
            end
        end
        vid_req = 1'b0; cpu_req = 1'b0;
        check("starve_ack_count", 32'(acks), 32'd18);
        tick();

        // Reset in the second ACCESS cycle of a CPU write aborts it.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0099; cpu_wdata = 16'hDEAD;
        tick();
        check("abort_we_c1", 32'(mem_we), 32'd1);
        tick();
        check("abort_we_c2", 32'(mem_we), 32'd1);
        @(negedge clk);
        reset = 1'b1; cpu_req = 1'b0;
        tick();
        check("abort_we_after", 32'(mem_we), 32'd0);
        check("abort_no_ack", 32'(cpu_ack), 32'd0);
        check("abort_mem_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cpu_seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (cpu_ack || mem_we || mem_oe) cpu_seen++;
        end
        check("abort_quiet", 32'(cpu_seen), 32'd0);
        run_vec('{1'b1, 1'b0, 16'h0099, 16'h0000, 16'h5A99});

        // Video request dropped mid-ACCESS still completes with one ack.
        ack_cnt = 0; ack_lat = -1; cpu_seen = 0;
        @(negedge clk);
        vid_req = 1'b1; vid_addr = 16'h0055;
        tick();
        @(negedge clk);
        vid_req = 1'b0;
        for (int k = 2; k <= 10; k++) begin
            tick();
            if (vid_ack) begin ack_cnt++; ack_lat = k; end
            if (cpu_ack) cpu_seen++;
        end
        check("drop_ack_count", 32'(ack_cnt), 32'd1);
        check("drop_ack_lat", 32'(ack_lat), 32'd3);
        check("drop_rdata", 32'(vid_rdata), 32'h5A55);
        check("drop_no_cpu_ack", 32'(cpu_seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ACCESS_CYCLES, default 2: number of cycles each memory access drives mem_* (range 1..15).
REQ-002 Parameter CPU_STARVE_MAX, default 8: consecutive video grants allowed while CPU is waiting (range 1..255).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 vid_req  input  1  video scanout fetch request, level, held until vid_ack.
REQ-006 vid_addr  input  16  video fetch word address.
REQ-007 vid_ack  output  1  one-cycle pulse; vid_rdata valid in the same cycle.
REQ-008 vid_rdata  output  16  video read data.
REQ-009 cpu_req  input  1  CPU request, level, held until cpu_ack.
REQ-010 cpu_we  input  1  1 = write, 0 = read; sampled at grant.
REQ-011 cpu_addr  input  16  CPU word address, sampled at grant.
REQ-012 cpu_wdata  input  16  CPU write data, sampled at grant.
REQ-013 cpu_ack  output  1  one-cycle pulse; cpu_rdata valid in the same cycle (reads).
REQ-014 cpu_rdata  output  16  CPU read data.
REQ-015 mem_addr  output  16  SRAM address.
REQ-016 mem_wdata  output  16  SRAM write data.
REQ-017 mem_we  output  1  SRAM write enable, active-high.
REQ-018 mem_oe  output  1  SRAM output enable, active-high.
REQ-019 mem_rdata  input  16  SRAM read data.

Function
REQ-020 FSM states: IDLE, ACCESS, DONE.
REQ-021 IDLE: sample requests. If any is granted, latch owner/addr/we/wdata and go to ACCESS next cycle. Otherwise stay in IDLE.
REQ-022 Priority: video wins over CPU, except when cpu_req=1 and streak==CPU_STARVE_MAX. In that case the CPU wins.
REQ-023 streak (8-bit): +1 on each video grant made while cpu_req=1; cleared on CPU grant; cleared on video grant made while cpu_req=0; saturates at CPU_STARVE_MAX.
REQ-024 ACCESS lasts exactly ACCESS_CYCLES cycles.
  - mem_addr/mem_wdata hold latched values throughout.
  - Read: mem_oe=1, mem_we=0.
  - Write: mem_we=1, mem_oe=0.
REQ-025 mem_rdata is registered at the last ACCESS cycle's rising edge into the owner's rdata register. The FSM then goes to DONE.
REQ-026 DONE lasts one cycle: owner's ack=1, mem_we=mem_oe=0, then back to IDLE.
REQ-027 Request-to-ack latency: grant edge G (cycle IDLE samples req); ack is high in cycle G+ACCESS_CYCLES+1. One access every ACCESS_CYCLES+2 cycles maximum.
REQ-028 Requests are not sampled in ACCESS or DONE. A requester drops or renews req after seeing ack, so there is no double grant.
REQ-029 cpu_we=1 accesses assert cpu_ack with cpu_rdata unchanged from its previous value.
REQ-030 Requester dropping req during ACCESS: the access still completes and ack still pulses.
REQ-031 Simultaneous vid_req and cpu_req with streak<CPU_STARVE_MAX: video granted, streak increments.
REQ-032 vid_ack and cpu_ack are never high in the same cycle.
REQ-033 mem_we is never high outside ACCESS.
REQ-034 Outside ACCESS, mem_addr and mem_wdata hold their last values.

Reset
REQ-035 On reset: state=IDLE, streak=0, vid_ack=cpu_ack=0, mem_we=mem_oe=0, mem_addr=0, mem_wdata=0, vid_rdata=0, cpu_rdata=0.
REQ-036 Reset during ACCESS or DONE aborts the access: no ack is issued, and mem_we=0 from the cycle after the reset edge.

Verification
REQ-037 CPU read alone, ACCESS_CYCLES=2, mem returns 0xBEEF at addr 0x1234 -> mem_oe high for 2 cycles, cpu_ack in cycle G+3 with cpu_rdata=0xBEEF.
REQ-038 CPU write 0xA5A5 to 0x0042 -> mem_we high for exactly 2 cycles with mem_addr=0x0042 and mem_wdata=0xA5A5; cpu_ack in G+3; mem_oe stays 0.
REQ-039 vid_req and cpu_req both continuously asserted, CPU_STARVE_MAX=8 -> grant order is 8 video then 1 CPU, repeating; no ack overlap.
REQ-040 Simultaneous first request of both -> video acked first; CPU acked ACCESS_CYCLES+2 cycles later.
REQ-041 Reset asserted in second ACCESS cycle of a CPU write -> mem_we=0 next cycle, no cpu_ack, state IDLE, streak=0.
REQ-042 vid_req dropped mid-ACCESS -> vid_ack still pulses once, then IDLE with no further grant.
